block_code_a20_encoder: RTL
===========================

# block_code_a20_encoder

Transmit-side (20,A) block encoder for the A20 uplink control path, per the TS 36.212 §5.2.3.3 basis-sequence code. It accepts one A-bit information word (1 ≤ A ≤ 13) per block, computes the 20-bit codeword, and streams it out one coded bit per beat under valid/ready flow control. Each bit is also mapped to a signed DATA_WIDTH symbol, so the output connects directly to the A20 receive chain for loopback verification.

## Interface
- DATA_WIDTH, 4: width of the signed output symbol; must match the receiver's symbol width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- info_bits  in  13  information word; info_bits[n] = a_n; bits n ≥ A are ignored.
- code_length  in  4  A, the number of valid information bits; legal range 1..13.
- in_valid  in  1  info_bits/code_length valid.
- in_ready  out  1  block can accept a word; high only in IDLE.
- tx_bit  out  1  coded bit b_i.
- tx_symbols  out  DATA_WIDTH  signed symbol for tx_bit: 0 → +(2^(DATA_WIDTH-1)-1), 1 → −(2^(DATA_WIDTH-1)-1). With DATA_WIDTH=4 this is ±7.
- tx_valid  out  1  tx_bit/tx_symbols valid.
- tx_ready  in  1  downstream accepts the beat.
- tx_last  out  1  high with the 20th beat (i = 19).
- err_len  out  1  one-cycle pulse when an illegal code_length is accepted.

## Operation
- FSM states: IDLE, ENCODE, SEND.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch info_bits masked to the low A bits, and latch code_length.
  - If A is 0 or > 13: pulse err_len on the next cycle, stay in IDLE, and emit no beats.
  - Otherwise go to ENCODE.
- ENCODE (1 cycle): register the codeword b_i = XOR over n < A of (a_n AND M[i][n]) for i = 0..19. Clear the beat counter and go to SEND.
- SEND:
  - tx_valid = 1 and tx_bit = codeword[idx], with idx counting 0..19.
  - A beat completes on tx_valid & tx_ready, and idx then increments.
  - tx_last = (idx == 19).
  - When the idx=19 beat completes, go to IDLE.
- Output order is b0 first.
- The codeword depends only on the masked information bits. Higher bits of info_bits never affect the output.
- Arithmetic is mod-2 only. idx is a 5-bit counter that never wraps past 19.

## Timing
- Reset values, held while rst = 1:
  - in_ready = 0, tx_valid = 0, tx_last = 0, err_len = 0, tx_bit = 0, tx_symbols = 0.
  - FSM = IDLE; in_ready rises in the first cycle after rst falls.
- Latency: with the input accepted at cycle T, ENCODE runs in T+1 and the first tx_valid appears in T+2.
- With tx_ready held high, beats occupy T+2..T+21 and in_ready is high again at T+22. The minimum block period is therefore 22 cycles.
- Backpressure: while tx_valid & !tx_ready, tx_bit, tx_symbols and tx_last hold stable and idx does not advance. tx_valid never drops mid-block.
- in_valid arriving outside IDLE is ignored; in_ready = 0 there.
- Illegal length: accepted at T, err_len pulses at T+1, in_ready stays high, and no tx_valid occurs.
- Reset mid-block abandons the codeword. No tx_last is issued, and the next block starts cleanly from IDLE.

## Structure
- Package block_code_a20_pkg holds:
  - constants N_CODE = 20 and A_MAX = 13;
  - the 20×13 basis table M (TS 36.212 Table 5.2.3.3-1) as a localparam array;
  - the state enum {IDLE, ENCODE, SEND}.
- Sub-module block_code_a20_codeword: a purely combinational function from (masked info, A) to the 20-bit codeword. The top level registers its output in ENCODE.

## Test plan
- A=1, info_bits=13'h0001, tx_ready=1: exactly 20 beats with tx_bit=1 and tx_symbols=−7 (column 0 of M is all ones); tx_last on beat 20; in_ready back 22 cycles after acceptance.
- A=13, info_bits=0: 20 beats, all tx_bit=0 and tx_symbols=+7.
- Linearity, A=13: encode the words x=13'h0A5B, y=13'h1234 and x^y; the codeword of x^y equals the bitwise XOR of the other two codewords. Compare against a reference model built from the package table.
- Masking: A=2 with info_bits=13'h1FFF produces the same 20 bits as A=2 with info_bits=13'h0003.
- Backpressure: drive tx_ready with a pseudo-random ~50% duty; the bit sequence is identical to the tx_ready=1 run, and outputs are stable during every stall.
- code_length=0 and code_length=14: err_len pulses once, tx_valid stays 0, and in_ready stays 1. Separately, assert rst at beat 10 of a legal block: all outputs are 0 during rst and the next block encodes correctly.

Source files
------------

// File: rtl/block_code_a20_encoder_pkg.sv
// -----------------------------------------------------------------------------
// block_code_a20_pkg
//   Shared definitions for the A20 uplink (20,A) block encoder:
//     N_CODE    - codeword length (20 coded bits per block)
//     A_MAX     - largest legal information word length (13 bits)
//     M         - 20x13 basis-sequence table; M[i][n] is the basis bit for
//                 coded bit i and information bit n
//     state_t   - encoder FSM states
//     len_mask  - helper returning a mask of the low A bits of a word
// -----------------------------------------------------------------------------
package block_code_a20_pkg;

    localparam int unsigned N_CODE = 20;
    localparam int unsigned A_MAX  = 13;

    // Row i is stored as a 13-bit vector with bit n = M[i][n]
    // (the literal reads column 12 on the left down to column 0 on the right).
    localparam logic [A_MAX-1:0] M [N_CODE] = '{
        13'b0110000000011,  // i = 0
        13'b0111000000111,  // i = 1
        13'b1111101001001,  // i = 2
        13'b1110100001101,  // i = 3
        13'b1110010001111,  // i = 4
        13'b1110111010011,  // i = 5
        13'b1111101010101,  // i = 6
        13'b1110110011001,  // i = 7
        13'b1111010011011,  // i = 8
        13'b1111001011101,  // i = 9
        13'b1111011100101,  // i = 10
        13'b1110101100111,  // i = 11
        13'b1111110101001,  // i = 12
        13'b1111010101011,  // i = 13
        13'b1010010110001,  // i = 14
        13'b1011011110011,  // i = 15
        13'b1101001110111,  // i = 16
        13'b1100100111001,  // i = 17
        13'b0000011111011,  // i = 18
        13'b0000001100001   // i = 19
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        SEND   = 2'd2
    } state_t;

    // Mask of the low len bits; lengths above A_MAX saturate to all ones.
    function automatic logic [A_MAX-1:0] len_mask(input logic [3:0] len);
        logic [A_MAX:0] t;
        t = (14'd1 << len) - 14'd1;
        return t[A_MAX-1:0];
    endfunction

endpackage

// File: rtl/block_code_a20_encoder_if.sv
// -----------------------------------------------------------------------------
// block_code_a20_encoder_if
//   Bundles the information-word input handshake and the coded-bit output
//   stream of the A20 block encoder.
//     info_bits   - information word, bit n = a_n
//     code_length - A, number of valid information bits
//     in_valid    - info_bits/code_length valid
//     in_ready    - encoder can accept a word
//     tx_bit      - coded bit b_i
//     tx_symbols  - signed symbol for tx_bit (0 -> +max, 1 -> -max)
//     tx_valid    - tx_bit/tx_symbols valid
//     tx_ready    - downstream accepts the beat
//     tx_last     - marks the 20th beat of a block
//     err_len     - one-cycle pulse on an illegal code_length
//   Modports: master = word source / beat sink, slave = encoder.
// -----------------------------------------------------------------------------
interface block_code_a20_encoder_if #(
    parameter int DATA_WIDTH = 4
);
    logic [12:0]                  info_bits;
    logic [3:0]                   code_length;
    logic                         in_valid;
    logic                         in_ready;
    logic                         tx_bit;
    logic signed [DATA_WIDTH-1:0] tx_symbols;
    logic                         tx_valid;
    logic                         tx_ready;
    logic                         tx_last;
    logic                         err_len;

    modport master (
        output info_bits, code_length, in_valid, tx_ready,
        input  in_ready, tx_bit, tx_symbols, tx_valid, tx_last, err_len
    );

    modport slave (
        input  info_bits, code_length, in_valid, tx_ready,
        output in_ready, tx_bit, tx_symbols, tx_valid, tx_last, err_len
    );
endinterface

// File: rtl/block_code_a20_encoder_codeword.sv
// -----------------------------------------------------------------------------
// block_code_a20_codeword
//   Purely combinational (20,A) codeword generator.
//     info     in  13  information word (bits n >= len are ignored)
//     len      in   4  A, number of valid information bits
//     codeword out 20  b_i = XOR over n < A of (a_n AND M[i][n])
// -----------------------------------------------------------------------------
module block_code_a20_codeword
    import block_code_a20_pkg::*;
(
    input  logic [A_MAX-1:0]  info,
    input  logic [3:0]        len,
    output logic [N_CODE-1:0] codeword
);

    logic [A_MAX-1:0] info_m;

    always_comb begin
        // Re-masking here keeps the codeword a function of a_0..a_{A-1}
        // alone, whatever the caller presents in the upper bits.
        info_m   = info & len_mask(len);
        codeword = '0;
        for (int unsigned i = 0; i < N_CODE; i++) begin
            codeword[i] = ^(info_m & M[i]);
        end
    end

endmodule

// File: rtl/block_code_a20_encoder.sv
// -----------------------------------------------------------------------------
// block_code_a20_encoder
//   Transmit-side (20,A) block encoder for the A20 uplink control path.
//   Accepts one A-bit information word per block, registers its 20-bit
//   codeword one cycle later, then streams the codeword b0 first, one bit
//   per beat, under valid/ready flow control with a signed symbol per bit.
//     clk  in  clock, rising edge
//     rst  in  synchronous active-high reset
//     bus  slave modport of block_code_a20_encoder_if
//   Block timing with tx_ready high: accept at T, encode at T+1,
//   beats T+2..T+21, in_ready again at T+22.
// -----------------------------------------------------------------------------
module block_code_a20_encoder
    import block_code_a20_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    block_code_a20_encoder_if.slave bus
);

    localparam logic [4:0] LAST_IDX = 5'(N_CODE - 1);
    localparam logic signed [DATA_WIDTH-1:0] SYM_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SYM_NEG = -SYM_POS;

    state_t            state;
    logic [A_MAX-1:0]  info_q;
    logic [3:0]        len_q;
    logic [N_CODE-1:0] cw_q;
    logic [N_CODE-1:0] cw_next;
    logic [4:0]        idx;
    logic              err_q;

    logic              accept;
    logic              len_illegal;

    block_code_a20_codeword u_codeword (
        .info     (info_q),
        .len      (len_q),
        .codeword (cw_next)
    );

    assign accept      = (state == IDLE) && bus.in_valid;
    assign len_illegal = (bus.code_length == 4'd0) || (bus.code_length > 4'(A_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            info_q <= '0;
            len_q  <= '0;
            cw_q   <= '0;
            idx    <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        info_q <= bus.info_bits & len_mask(bus.code_length);
                        len_q  <= bus.code_length;
                        if (len_illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            state <= ENCODE;
                        end
                    end
                end
                ENCODE: begin
                    cw_q  <= cw_next;
                    idx   <= '0;
                    state <= SEND;
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so that a reset asserted
    // mid-block silences the stream in the same cycle it is applied.
    always_comb begin
        bus.in_ready   = 1'b0;
        bus.tx_valid   = 1'b0;
        bus.tx_bit     = 1'b0;
        bus.tx_symbols = '0;
        bus.tx_last    = 1'b0;
        bus.err_len    = 1'b0;
        if (!rst) begin
            bus.in_ready = (state == IDLE);
            bus.err_len  = err_q;
            if (state == SEND) begin
                bus.tx_valid   = 1'b1;
                bus.tx_bit     = cw_q[idx];
                bus.tx_symbols = cw_q[idx] ? SYM_NEG : SYM_POS;
                bus.tx_last    = (idx == LAST_IDX);
            end
        end
    end

endmodule
